prime_scan_ctrl: RTL and testbench

- Sequential range scanner that sits directly upstream of the combinational 4-bit prime/multiple indicator.
- On a start request it walks cur_num from lo to hi, one value per clock, and presents each value to the indicator.
- It samples the indicator's prime and multiple flags returned in the same cycle and accumulates per-flag hit counts.
- It reports completion with a one-cycle done pulse and holds the counts until the next accepted start.

---
 rtl/prime_scan_ctrl_pkg.sv | 22 ++
 rtl/prime_scan_ctrl_hit_counter.sv | 21 ++
 rtl/prime_scan_ctrl.sv | 97 +++++++++
 tb/tb_prime_scan_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prime_scan_ctrl_pkg.sv
// Shared constants for the prime/multiple range scanner: widths, flag indices
// and the controller state encoding.
package prime_scan_ctrl_pkg;

  localparam int NUM_W = 4;
  localparam int CNT_W = 5;
  localparam int MUL_N = 5;

  // Bit positions of the indicator's multiple flags within is_mul.
  localparam int MUL11 = 4;
  localparam int MUL7  = 3;
  localparam int MUL5  = 2;
  localparam int MUL3  = 1;
  localparam int MUL1  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/prime_scan_ctrl_hit_counter.sv
// Saturation-free hit counter with synchronous clear and count enable;
// sized by the caller so that a full scan can never overflow it.
module hit_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/prime_scan_ctrl.sv
// Walks cur_num from lo to hi (inclusive), one value per clock, and counts
// the prime and multiple flags the downstream indicator returns for each value.
module prime_scan_ctrl #(
  parameter int NUM_W = prime_scan_ctrl_pkg::NUM_W,
  parameter int CNT_W = prime_scan_ctrl_pkg::CNT_W,
  parameter int MUL_N = prime_scan_ctrl_pkg::MUL_N
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_W-1:0]       lo,
  input  logic [NUM_W-1:0]       hi,
  output logic [NUM_W-1:0]       cur_num,
  input  logic                   is_prime,
  input  logic [MUL_N-1:0]       is_mul,
  output logic                   busy,
  output logic                   done,
  output logic                   range_err,
  output logic [CNT_W-1:0]       prime_cnt,
  output logic [MUL_N*CNT_W-1:0] mul_cnt,
  output logic [1:0]             state_dbg
);

  import prime_scan_ctrl_pkg::*;

  // Handshake: start is a level request taken only while idle (accept);
  // nothing ever stalls it, and a start raised during SCAN/DONE is discarded.
  state_t           state_q;
  state_t           state_d;
  logic [NUM_W-1:0] hi_q;
  logic             accept;
  logic             scan;

  assign accept = (state_q == ST_IDLE) && start;
  assign scan   = (state_q == ST_SCAN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (lo > hi) ? ST_DONE : ST_SCAN;
      ST_SCAN: if (cur_num == hi_q) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // busy/done decode the state register only, so they carry no input paths.
  always_comb begin
    busy      = scan;
    done      = (state_q == ST_DONE);
    state_dbg = state_q;
  end

  // Stopping on the compare with the latched hi keeps cur_num from wrapping at 15.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_num   <= '0;
      hi_q      <= '0;
      range_err <= 1'b0;
    end else if (accept) begin
      range_err <= (lo > hi);
      if (lo <= hi) begin
        hi_q    <= hi;
        cur_num <= lo;
      end
    end else if (scan && (cur_num != hi_q)) begin
      cur_num <= cur_num + NUM_W'(1);
    end
  end

  hit_counter #(.CNT_W(CNT_W)) u_prime_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (scan && is_prime),
    .count  (prime_cnt)
  );

  for (genvar i = 0; i < MUL_N; i++) begin : g_mul
    hit_counter #(.CNT_W(CNT_W)) u_mul_cnt (
      .clk    (clk),
      .reset  (reset),
      .clear  (accept),
      .enable (scan && is_mul[i]),
      .count  (mul_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_prime_scan_ctrl.sv
// Bench for prime_scan_ctrl with a lookup-table indicator wired between
// cur_num and the flag inputs; counts are predicted by trial-division arithmetic.
module tb_prime_scan_ctrl;

  import prime_scan_ctrl_pkg::*;

  localparam int MW = MUL_N * CNT_W;

  // Indicator truth tables, one bit per value 0..15.
  localparam logic [15:0] PRIME_TAB = 16'h28AC;
  localparam logic [15:0] M11_TAB   = 16'h0800;
  localparam logic [15:0] M7_TAB    = 16'h4080;
  localparam logic [15:0] M5_TAB    = 16'h8420;
  localparam logic [15:0] M3_TAB    = 16'h9248;
  localparam logic [15:0] M1_TAB    = 16'hFFFE;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [NUM_W-1:0] lo;
  logic [NUM_W-1:0] hi;
  logic [NUM_W-1:0] cur_num;
  logic             is_prime;
  logic [MUL_N-1:0] is_mul;
  logic             busy;
  logic             done;
  logic             range_err;
  logic [CNT_W-1:0] prime_cnt;
  logic [MW-1:0]    mul_cnt;
  logic [1:0]       state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  logic [NUM_W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  prime_scan_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .lo        (lo),
    .hi        (hi),
    .cur_num   (cur_num),
    .is_prime  (is_prime),
    .is_mul    (is_mul),
    .busy      (busy),
    .done      (done),
    .range_err (range_err),
    .prime_cnt (prime_cnt),
    .mul_cnt   (mul_cnt),
    .state_dbg (state_dbg)
  );

  always_comb begin
    is_prime = PRIME_TAB[cur_num];
    is_mul   = {M11_TAB[cur_num], M7_TAB[cur_num], M5_TAB[cur_num],
                M3_TAB[cur_num], M1_TAB[cur_num]};
  end

  // ---------------- reference model ----------------
  function automatic bit model_prime(int v);
    if (v < 2) return 1'b0;
    for (int d = 2; d * d <= v; d++) if (v % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [MW-1:0] pk(int m11, int m7, int m5, int m3, int m1);
    return {CNT_W'(m11), CNT_W'(m7), CNT_W'(m5), CNT_W'(m3), CNT_W'(m1)};
  endfunction

  task automatic model_counts(input int l, input int h,
                              output logic [CNT_W-1:0] p, output logic [MW-1:0] m);
    int fac[MUL_N] = '{1, 3, 5, 7, 11};
    int cnt[MUL_N] = '{0, 0, 0, 0, 0};
    int pc = 0;
    for (int v = l; v <= h; v++) begin
      if (model_prime(v)) pc++;
      for (int f = 0; f < MUL_N; f++) if (v != 0 && v % fac[f] == 0) cnt[f]++;
    end
    p = CNT_W'(pc);
    m = pk(cnt[MUL11], cnt[MUL7], cnt[MUL5], cnt[MUL3], cnt[MUL1]);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Issues one start and follows it to the done pulse, checking the cur_num
  // sequence, latency, busy length and final counts.
  task automatic run_scan(input int l, input int h, input bit hold,
                          input logic [CNT_W-1:0] ep, input logic [MW-1:0] em,
                          input bit eerr, input bit scramble);
    int n      = (l <= h) ? (h - l + 1) : 0;
    int busy_n = 0;
    int done_c = -1;
    logic [NUM_W-1:0] cur_before = cur_num;
    logic [NUM_W-1:0] e;
    exp_q.delete();
    for (int v = l; v <= h; v++) exp_q.push_back(NUM_W'(v));
    start = 1'b1;
    lo    = NUM_W'(l);
    hi    = NUM_W'(h);
    for (int c = 1; c <= 40 && done_c < 0; c++) begin
      step();
      if (!hold) start = 1'b0;
      if (scramble) begin
        lo = NUM_W'($urandom);
        hi = NUM_W'($urandom);
      end
      if (busy) begin
        busy_n++;
        if (exp_q.size() == 0) chk("cur_num_extra", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("cur_num", cur_num, e);
        end
      end
      if (done) done_c = c;
    end
    chk("done_latency", done_c, n + 1);
    chk("busy_cycles", busy_n, n);
    chk("prime_cnt", prime_cnt, ep);
    chk("mul_cnt", mul_cnt, em);
    chk("range_err", range_err, eerr);
    chk("cur_num_hold", cur_num, (n > 0) ? NUM_W'(h) : cur_before);
    if (!hold) begin
      step();
      chk("done_width", done, 0);
      chk("idle_after_done", state_dbg, ST_IDLE);
      chk("prime_cnt_held", prime_cnt, ep);
      chk("mul_cnt_held", mul_cnt, em);
    end
  endtask

  // ---------------- test ----------------
  typedef struct {
    int               lo;
    int               hi;
    logic [CNT_W-1:0] prime;
    logic [MW-1:0]    mul;
    bit               err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [CNT_W-1:0] rp;
    logic [MW-1:0]    rm;
    int               seen_done;

    vecs[0] = '{0, 15, 5'd6, pk(1, 2, 3, 5, 15), 1'b0};
    vecs[1] = '{5, 5,  5'd1, pk(0, 0, 1, 0, 1),  1'b0};
    vecs[2] = '{9, 3,  5'd0, pk(0, 0, 0, 0, 0),  1'b1};
    vecs[3] = '{2, 3,  5'd2, pk(0, 0, 0, 1, 2),  1'b0};
    vecs[4] = '{15, 15, 5'd0, pk(0, 0, 1, 1, 1), 1'b0};
    vecs[5] = '{0, 0,  5'd0, pk(0, 0, 0, 0, 0),  1'b0};

    lo = '0;
    hi = '0;
    do_reset();
    chk("rst_state", state_dbg, ST_IDLE);
    chk("rst_cur_num", cur_num, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_range_err", range_err, 0);
    chk("rst_prime_cnt", prime_cnt, 0);
    chk("rst_mul_cnt", mul_cnt, 0);

    for (int i = 0; i < 6; i++) begin
      run_scan(vecs[i].lo, vecs[i].hi, 1'b0, vecs[i].prime, vecs[i].mul, vecs[i].err, 1'b0);
      repeat (2) step();
    end

    // Start held high across a whole scan: one scan, then a fresh one right after IDLE.
    run_scan(12, 15, 1'b1, 5'd1, pk(0, 1, 1, 2, 4), 1'b0, 1'b0);
    step();
    chk("hold_idle_state", state_dbg, ST_IDLE);
    chk("hold_idle_busy", busy, 0);
    chk("hold_idle_done", done, 0);
    step();
    chk("hold_rescan_busy", busy, 1);
    chk("hold_rescan_cur", cur_num, 12);
    start = 1'b0;
    do_reset();

    // Reset on the third SCAN cycle discards the partial scan.
    start = 1'b1;
    lo    = 4'd0;
    hi    = 4'd15;
    step();
    start = 1'b0;
    step();
    step();
    chk("mid_scan_busy", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_state", state_dbg, ST_IDLE);
    chk("mr_cur_num", cur_num, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_range_err", range_err, 0);
    chk("mr_prime_cnt", prime_cnt, 0);
    chk("mr_mul_cnt", mul_cnt, 0);
    seen_done = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (done || busy) seen_done++;
    end
    chk("mr_no_activity", seen_done, 0);

    // Random ranges against the arithmetic model, with lo/hi disturbed after acceptance.
    for (int r = 0; r < 40; r++) begin
      int l = $urandom_range(0, 15);
      int h = $urandom_range(0, 15);
      model_counts(l, h, rp, rm);
      run_scan(l, h, 1'b0, rp, rm, (l > h), 1'b1);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
